serial_rx: RTL and testbench

- Receives an asynchronous serial bit stream on a single input line and reassembles it into parallel words.
- Frame format: start bit (0), DATA_BITS data bits LSB first, one stop bit (1). Idle line is 1.
- It is the consumer end of the team's serial bit-stream path, turning a serial D-line back into words.
- It sits behind any flip-flop or shift stage that produces the line and feeds parallel logic with a one-cycle valid pulse.

---
 rtl/serial_rx.sv | 119 +++++++++++
 tb/tb_serial_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - start/data/stop serial line receiver, centre-sampled, LSB first
// Two-flop synchronizer feeds a single-process FSM; valid/frame_err are one-cycle pulses.
module serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shift_next;

  assign rx_s = sync2;

  // New bit enters at the MSB so the first received bit ends up in bit 0.
  always_comb begin
    shift_next                = shreg >> 1;
    shift_next[DATA_BITS-1]   = rx_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shreg   <= shift_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a start bit right after it be caught.
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx (default parameters)
`timescale 1ns/1ps
module tb_serial_rx;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  serial_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       v;
    logic       e;
    logic [7:0] d;
  } pulse_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
  } vec_t;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] model = 8'h00;
  pulse_t     exp_q[$];
  pulse_t     obs_q[$];
  vec_t       vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && (valid || frame_err)) begin
      obs_q.push_back('{cyc: cyc, v: valid, e: frame_err, d: data});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a falling edge; a start bit set here is captured by the next rising edge (T).
  task automatic send_frame(input logic [7:0] d, input logic stop);
    pulse_t e;
    if (stop) model = d;
    e.cyc = cyc + 41;
    e.v   = stop;
    e.e   = !stop;
    e.d   = model;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (4) @(negedge clk);
    end
    rx = stop;
    repeat (4) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain();
    pulse_t e;
    pulse_t o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("pulse_cycle", o.cyc, e.cyc);
      check("pulse_valid", {31'b0, o.v}, {31'b0, e.v});
      check("pulse_err", {31'b0, o.e}, {31'b0, e.e});
      check("pulse_data", {24'b0, o.d}, {24'b0, e.d});
    end
    check("missing_pulses", exp_q.size(), 0);
    check("extra_pulses", obs_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    drain();
    check("data_held", {24'b0, data}, {24'b0, model});
    check("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    vecs[0] = '{d: 8'hA5, stop: 1'b1, gap: 10};
    vecs[1] = '{d: 8'h3C, stop: 1'b1, gap: 0};
    vecs[2] = '{d: 8'hFF, stop: 1'b1, gap: 10};
    vecs[3] = '{d: 8'h81, stop: 1'b0, gap: 12};
    vecs[4] = '{d: 8'h01, stop: 1'b1, gap: 0};
    vecs[5] = '{d: 8'h80, stop: 1'b1, gap: 0};
    vecs[6] = '{d: 8'h55, stop: 1'b1, gap: 10};

    reset_n = 1'b0;
    rx      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = ~rx;
      check("reset_hold_outputs", {21'b0, data, valid, frame_err, busy}, 32'd0);
    end
    rx      = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle_outputs", {21'b0, data, valid, frame_err, busy}, 32'd0);
    end

    // Table of frames: back-to-back where gap is 0, framing error on 0x81.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].stop);
      if (vecs[i].gap > 0) settle(vecs[i].gap);
    end

    // False start: one-cycle low pulse.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("false_start_busy_cycles", busy_cnt, 2);
    settle(2);
    send_frame(8'h00, 1'b1);
    settle(10);

    // Reset during the 4th data bit of a frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(i[0]);
      repeat (4) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe_reset_outputs", {21'b0, data, valid, frame_err, busy}, 32'd0);
    model   = 8'h00;
    reset_n = 1'b1;
    settle(10);
    send_frame(8'h5A, 1'b1);
    settle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
